wave_gen: RTL
=============

Name: wave_gen

Overview:
Parametrised multi-waveform oscillator voice for the tracker audio path. A phase accumulator advances once per sample tick. The top phase bits address a LUT-free shaper, which produces a signed saw, ramp-down, variable-duty square or triangle sample. The block has a 2-stage registered pipeline with a valid pulse, glitch-free mode switching at phase wrap, and note retrigger.

Parameters:
PHASE_W, 24, phase accumulator width; frequency resolution is fs/2^PHASE_W.
ADDR_W, 9, number of phase MSBs used as the shaper address.
OUT_W, 16, signed sample width; must satisfy OUT_W >= ADDR_W+1 (elaboration assertion).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_tick  in  1  advance-phase / produce-sample strobe, 1 cycle wide
freq_inc  in  PHASE_W  unsigned phase increment per tick
mode  in  2  requested waveform: 0 saw, 1 ramp-down, 2 square, 3 triangle
duty  in  ADDR_W  square high threshold, unsigned
retrigger  in  1  restart phase at 0 and load mode immediately
sample_out  out  OUT_W  signed two's-complement sample
sample_valid  out  1  1-cycle pulse, sample_out is new
wrap  out  1  1-cycle pulse, accumulator carried out

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high. All logic is sampled on the rising edge of clk.
- Reset values: phase=0, active_mode=0 (saw), stage-1 valid=0, sample_out=0, sample_valid=0, wrap=0. Inputs are ignored while reset=1.
- Reset mid-operation flushes the pipeline. No sample_valid is issued for ticks in flight.
- Phase update at an edge (priority order):
  - retrigger & sample_tick: phase <= freq_inc.
  - retrigger only: phase <= 0.
  - sample_tick only: phase <= phase + freq_inc, mod 2^PHASE_W.
  - neither: hold.
- Mode selection:
  - wrap_evt = carry-out of phase+freq_inc on a tick without retrigger.
  - active_mode <= mode when wrap_evt or retrigger; otherwise it holds.
  - mode_eff = retrigger ? mode : active_mode.
- Stage 1 registers on the tick edge:
  - s1_addr = retrigger ? 0 : phase[PHASE_W-1 -: ADDR_W], taken from the pre-update phase.
  - s1_mode = mode_eff.
  - s1_valid = sample_tick.
  - wrap <= wrap_evt, which is high in the cycle after the tick edge.
- Stage 2, one edge later, when s1_valid=1:
  - sample_out <= shape(s1_addr, s1_mode); sample_valid <= 1.
  - Otherwise sample_out holds and sample_valid <= 0.
- Latency: sample_tick high before edge E0 gives sample_valid high in the cycle after edge E1, i.e. 2 clocks.
- Throughput: a tick every cycle is supported, giving one sample per cycle.
- Shaper, with A = s1_addr, S = OUT_W-ADDR_W, H = 2^(OUT_W-1):
  - saw: (A<<S) - H, i.e. invert the MSB of A<<S.
  - ramp-down: bitwise NOT of the saw value.
  - square: A < duty gives H-1, else -H. duty=0 gives constant -H.
  - triangle: r = A[ADDR_W-1] ? ~A[ADDR_W-2:0] : A[ADDR_W-2:0]; out = (r<<(S+1)) - H.
  - All results are exact within OUT_W; no saturation logic is needed.
- Boundary cases:
  - freq_inc=0: constant output, no wrap.
  - freq_inc=2^PHASE_W-1: phase steps backwards by 1 LSB, wrapping every tick except from phase 0.
  - A mode change mid-period is deferred to the next wrap. The sample computed on the wrapping tick still uses the old mode, because the address is the pre-update phase.
  - Retrigger without a tick produces no sample.

Test Plan:
1. Defaults, freq_inc=0x008000, mode=0, ticks every cycle from reset → sample_out sequence -32768, -32640, -32512 …; the 512th sample is 32640; wrap pulses once per 512 ticks; valid 2 clocks after each tick.
2. Triangle, mode=3 applied at reset release, same freq_inc → A=0: -32768, A=255: 32512, A=256: 32512, A=511: -32768; symmetric sequence.
3. Square, mode=2, duty=128 → 128 samples of 32767, then 384 of -32768 per period; duty=0 → all -32768.
4. mode changed 0→1 at A=100 → saw continues through A=511; the first sample after the wrap (A=0) is 32767 (ramp-down).
5. retrigger+tick at A=300 with mode=3 → next sample is -32768 (A=0, triangle), phase=freq_inc; retrigger alone → no valid, next tick samples A=0.
6. reset asserted the cycle after a tick → no sample_valid; all outputs 0 the cycle after reset; the first post-reset tick yields -32768 (saw, A=0).

Source files
------------

// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator oscillator voice with a LUT-free shaper.
// Produces signed saw, ramp-down, variable-duty square or triangle samples
// through a 2-stage registered pipeline. Mode changes are deferred to the
// next phase wrap; retrigger restarts the phase and loads the mode at once.
module wave_gen #(
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned OUT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic [PHASE_W-1:0]       freq_inc,
    input  logic [1:0]               mode,
    input  logic [ADDR_W-1:0]        duty,
    input  logic                     retrigger,
    output logic signed [OUT_W-1:0]  sample_out,
    output logic                     sample_valid,
    output logic                     wrap
);

    // Number of zero bits appended below the shaper address.
    localparam int unsigned SHIFT_W = OUT_W - ADDR_W;

    // Elaboration-time parameter sanity checks.
    generate
        if (OUT_W < ADDR_W + 1) begin : g_bad_out_w
            $error("wave_gen: OUT_W must be >= ADDR_W+1");
        end
        if (ADDR_W < 2) begin : g_bad_addr_w
            $error("wave_gen: ADDR_W must be >= 2 for the triangle fold");
        end
        if (PHASE_W < ADDR_W) begin : g_bad_phase_w
            $error("wave_gen: PHASE_W must be >= ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    // Architectural state
    logic [PHASE_W-1:0]  r_phase;
    mode_t               r_active_mode;

    // Stage 1 registers
    logic [ADDR_W-1:0]   r_s1_addr;
    mode_t               r_s1_mode;
    logic                r_s1_valid;
    logic                r_wrap;

    // Stage 2 registers
    logic [OUT_W-1:0]    r_sample;
    logic                r_sample_valid;

    // Combinational nets
    mode_t               w_mode_req;
    logic [PHASE_W:0]    w_sum;
    logic                w_wrap_evt;
    logic [PHASE_W-1:0]  w_phase_nxt;
    mode_t               w_active_mode_nxt;
    mode_t               w_mode_eff;
    logic [ADDR_W-1:0]   w_addr_nxt;

    logic [OUT_W-1:0]    w_saw_u;
    logic [OUT_W-1:0]    w_saw;
    logic [ADDR_W-2:0]   w_tri_r;
    logic [OUT_W-1:0]    w_tri_u;
    logic [OUT_W-1:0]    w_tri;
    logic [OUT_W-1:0]    w_square;
    logic [OUT_W-1:0]    w_shape;

    assign w_mode_req = mode_t'(mode);

    // Accumulator sum with carry-out; the carry marks a phase wrap.
    assign w_sum      = {1'b0, r_phase} + {1'b0, freq_inc};
    assign w_wrap_evt = sample_tick & ~retrigger & w_sum[PHASE_W];

    // Next phase and next active mode, retrigger taking priority over tick.
    always_comb begin
        w_phase_nxt       = r_phase;
        w_active_mode_nxt = r_active_mode;
        w_mode_eff        = r_active_mode;
        w_addr_nxt        = r_phase[PHASE_W-1 -: ADDR_W];

        if (retrigger && sample_tick) begin
            w_phase_nxt = freq_inc;
        end else if (retrigger) begin
            w_phase_nxt = '0;
        end else if (sample_tick) begin
            w_phase_nxt = w_sum[PHASE_W-1:0];
        end

        if (w_wrap_evt || retrigger) begin
            w_active_mode_nxt = w_mode_req;
        end

        if (retrigger) begin
            w_mode_eff = w_mode_req;
            w_addr_nxt = '0;
        end
    end

    // Phase accumulator, active mode and stage-1 pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase       <= '0;
            r_active_mode <= MODE_SAW;
            r_s1_addr     <= '0;
            r_s1_mode     <= MODE_SAW;
            r_s1_valid    <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_active_mode <= w_active_mode_nxt;
            r_s1_valid    <= sample_tick;
            r_wrap        <= w_wrap_evt;
            if (sample_tick) begin
                r_s1_addr <= w_addr_nxt;
                r_s1_mode <= w_mode_eff;
            end
        end
    end

    // Shaper: subtracting H from an unsigned value is a flip of its MSB.
    always_comb begin
        w_saw_u  = {r_s1_addr, {SHIFT_W{1'b0}}};
        w_saw    = {~w_saw_u[OUT_W-1], w_saw_u[OUT_W-2:0]};

        w_tri_r  = r_s1_addr[ADDR_W-1] ? ~r_s1_addr[ADDR_W-2:0]
                                       :  r_s1_addr[ADDR_W-2:0];
        w_tri_u  = {w_tri_r, {(SHIFT_W+1){1'b0}}};
        w_tri    = {~w_tri_u[OUT_W-1], w_tri_u[OUT_W-2:0]};

        w_square = (r_s1_addr < duty) ? {1'b0, {(OUT_W-1){1'b1}}}
                                      : {1'b1, {(OUT_W-1){1'b0}}};

        w_shape  = w_saw;
        case (r_s1_mode)
            MODE_SAW:    w_shape = w_saw;
            MODE_RAMP:   w_shape = ~w_saw;
            MODE_SQUARE: w_shape = w_square;
            MODE_TRI:    w_shape = w_tri;
            default:     w_shape = w_saw;
        endcase
    end

    // Stage 2: register the shaped sample and the valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else if (r_s1_valid) begin
            r_sample       <= w_shape;
            r_sample_valid <= 1'b1;
        end else begin
            r_sample_valid <= 1'b0;
        end
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_sample_valid;
    assign wrap         = r_wrap;

endmodule
